tim_slave_ctrl: RTL and testbench

- Slave-mode controller for one general-purpose timer.
- Selects a trigger source (TRGI) and decides, each cycle, whether the time-base counter ticks, in which direction, and when it is re-initialised.
- Also requests CEN set/clear from the register block.
- Sits between the capture/compare channels and inter-timer trigger inputs on one side, and the time-base unit on the other.

---
 rtl/tim_pkg.sv | 46 ++++
 rtl/tim_encoder_if.sv | 67 ++++++
 rtl/tim_slave_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_tim_slave_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tim_pkg
// Description : Shared types for the timer slave-mode controller: slave mode
//               and trigger source encodings plus the encoder mode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tim_pkg;

    // Slave mode select encodings
    typedef enum logic [2:0] {
        SMS_DIS     = 3'b000,
        SMS_ENC2    = 3'b001,
        SMS_ENC1    = 3'b010,
        SMS_ENC3    = 3'b011,
        SMS_RESET   = 3'b100,
        SMS_GATED   = 3'b101,
        SMS_TRIGGER = 3'b110,
        SMS_EXTCLK1 = 3'b111
    } sms_e;

    // Trigger source select encodings
    typedef enum logic [2:0] {
        TS_ITR0    = 3'b000,
        TS_ITR1    = 3'b001,
        TS_ITR2    = 3'b010,
        TS_ITR3    = 3'b011,
        TS_TI1F_ED = 3'b100,
        TS_TI1FP1  = 3'b101,
        TS_TI2FP2  = 3'b110,
        TS_ETRF    = 3'b111
    } ts_e;

    // Number of internal trigger inputs the TS encoding addresses
    localparam int C_ITR_NUM = 4;

    // Encoder sub-mode: bit1 counts TI1 edges, bit0 counts TI2 edges.
    // Non-encoder slave modes map to 2'b00 so the decoder stays idle.
    function automatic logic [1:0] enc_mode(input sms_e sms);
        logic [2:0] v;
        v = sms;
        return v[2] ? 2'b00 : v[1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/tim_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : tim_encoder_if
// Description : Quadrature decoder for TI1FP1/TI2FP2. Detects edges on either
//               input, derives count direction and a tick for the selected
//               encoder sub-mode. Tick and direction are combinational; the
//               parent registers them.
// Revision    : 1.0 - initial release
// ============================================================================
module tim_encoder_if
    import tim_pkg::*;
(
    input  logic       clk_i,
    input  logic       aresetn_i,
    input  logic [1:0] mode,
    input  logic       cen_i,
    input  logic       ti1fp1_i,
    input  logic       ti2fp2_i,
    output logic       tick,
    output logic       dir
);

    logic r_ti1_q;
    logic r_ti2_q;
    logic r_armed;
    logic r_dir;

    logic w_e1;
    logic w_e2;
    logic w_cnt1;
    logic w_cnt2;
    logic w_down;
    logic w_xor;

    // Edges are masked for the first cycle after reset release so a high
    // input level is not mistaken for a transition from the reset value.
    assign w_e1 = r_armed & (ti1fp1_i ^ r_ti1_q);
    assign w_e2 = r_armed & (ti2fp2_i ^ r_ti2_q);

    // Both inputs moving together is an illegal quadrature step: ignored.
    assign w_cnt1 = mode[1] & w_e1 & ~w_e2;
    assign w_cnt2 = mode[0] & w_e2 & ~w_e1;

    // TI1 edge: down = TI1 XNOR TI2; TI2 edge: down = TI2 XOR TI1.
    assign w_xor  = ti1fp1_i ^ ti2fp2_i;
    assign w_down = w_cnt1 ? ~w_xor : w_xor;

    assign tick = (w_cnt1 | w_cnt2) & cen_i;
    assign dir  = (w_cnt1 | w_cnt2) ? w_down : r_dir;

    // Track previous input levels and hold the last decoded direction
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_ti1_q <= 1'b0;
            r_ti2_q <= 1'b0;
            r_armed <= 1'b0;
            r_dir   <= 1'b0;
        end else begin
            r_ti1_q <= ti1fp1_i;
            r_ti2_q <= ti2fp2_i;
            r_armed <= 1'b1;
            r_dir   <= dir;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tim_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tim_slave_ctrl
// Description : Slave-mode controller for a general-purpose timer. Selects
//               the trigger input, detects its edges, and decides per cycle
//               whether the counter ticks, its direction, re-initialisation
//               and CEN set/clear requests. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module tim_slave_ctrl
    import tim_pkg::*;
#(
    parameter int ITR_NUM = 4
) (
    input  logic               clk_i,
    input  logic               aresetn_i,
    input  logic [2:0]         sms_i,
    input  logic [2:0]         ts_i,
    input  logic               msm_i,
    input  logic               cen_i,
    input  logic               opm_i,
    input  logic               dir_i,
    input  logic               uev_i,
    input  logic [ITR_NUM-1:0] itr_i,
    input  logic               ti1f_ed_i,
    input  logic               ti1fp1_i,
    input  logic               ti2fp2_i,
    input  logic               etrf_i,
    output logic               cnt_tick_o,
    output logic               cnt_dir_o,
    output logic               cnt_reinit_o,
    output logic               cen_set_o,
    output logic               cen_clr_o,
    output logic               trgi_o,
    output logic               tif_o
);

    sms_e       w_sms;
    ts_e        w_ts;

    logic [2:0] r_sms_q;
    logic [2:0] r_ts_q;
    logic       r_armed;
    logic       r_trgi_q;
    logic       r_edge_d;
    logic       r_fall_d;
    logic       r_trgi_d;

    logic       w_trgi;
    logic       w_chg;
    logic       w_edge;
    logic       w_fall;
    logic       w_edge_e;
    logic       w_fall_e;
    logic       w_trgi_e;

    logic [1:0] w_enc_mode;
    logic       w_enc_tick;
    logic       w_enc_dir;

    logic       w_tick_n;
    logic       w_dir_n;
    logic       w_reinit_n;
    logic       w_tif_n;
    logic       w_set_n;
    logic       w_clr_n;

    assign w_sms = sms_e'(sms_i);
    assign w_ts  = ts_e'(ts_i);

    // Trigger source multiplexer (TRGI)
    always_comb begin
        w_trgi = 1'b0;
        case (w_ts)
            TS_ITR0:    w_trgi = itr_i[0];
            TS_ITR1:    w_trgi = itr_i[1];
            TS_ITR2:    w_trgi = itr_i[2];
            TS_ITR3:    w_trgi = itr_i[3];
            TS_TI1F_ED: w_trgi = ti1f_ed_i;
            TS_TI1FP1:  w_trgi = ti1fp1_i;
            TS_TI2FP2:  w_trgi = ti2fp2_i;
            TS_ETRF:    w_trgi = etrf_i;
            default:    w_trgi = 1'b0;
        endcase
    end

    // A mode or source change (or the first cycle out of reset) only
    // re-samples TRGI; comparing against a stale level would fake an edge.
    assign w_chg  = ~r_armed | (sms_i != r_sms_q) | (ts_i != r_ts_q);
    assign w_edge = ~w_chg & ((w_ts == TS_TI1F_ED) ? ti1f_ed_i : (w_trgi & ~r_trgi_q));
    assign w_fall = ~w_chg & ~w_trgi & r_trgi_q;

    // Master/slave mode adds one cycle to trigger effects, gate level included
    assign w_edge_e = msm_i ? r_edge_d : w_edge;
    assign w_fall_e = msm_i ? r_fall_d : w_fall;
    assign w_trgi_e = msm_i ? r_trgi_d : w_trgi;

    assign w_enc_mode = enc_mode(w_sms);

    tim_encoder_if u_enc (
        .clk_i     (clk_i),
        .aresetn_i (aresetn_i),
        .mode      (w_enc_mode),
        .cen_i     (cen_i),
        .ti1fp1_i  (ti1fp1_i),
        .ti2fp2_i  (ti2fp2_i),
        .tick      (w_enc_tick),
        .dir       (w_enc_dir)
    );

    // Per-mode next values for the registered outputs
    always_comb begin
        w_tick_n   = cen_i;
        w_dir_n    = dir_i;
        w_reinit_n = 1'b0;
        w_tif_n    = 1'b0;
        w_set_n    = 1'b0;
        w_clr_n    = opm_i & uev_i & cen_i;
        case (w_sms)
            SMS_ENC2, SMS_ENC1, SMS_ENC3: begin
                w_tick_n = w_enc_tick;
                w_dir_n  = w_enc_dir;
            end
            SMS_RESET: begin
                w_reinit_n = w_edge_e;
                w_tif_n    = w_edge_e;
            end
            SMS_GATED: begin
                w_tick_n = cen_i & w_trgi_e;
                w_tif_n  = w_edge_e | w_fall_e;
            end
            SMS_TRIGGER: begin
                w_tif_n = w_edge_e;
                w_set_n = w_edge_e & ~cen_i;
            end
            SMS_EXTCLK1: begin
                w_tick_n = w_edge_e & cen_i;
                w_tif_n  = w_edge_e;
            end
            default: ;
        endcase
        // Stopping the counter takes precedence over starting it
        if (w_clr_n) begin
            w_set_n = 1'b0;
        end
    end

    // Trigger tracking: previous level, mode/source copies, msm delay stage
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            r_sms_q  <= 3'b000;
            r_ts_q   <= 3'b000;
            r_armed  <= 1'b0;
            r_trgi_q <= 1'b0;
            r_edge_d <= 1'b0;
            r_fall_d <= 1'b0;
            r_trgi_d <= 1'b0;
        end else begin
            r_sms_q  <= sms_i;
            r_ts_q   <= ts_i;
            r_armed  <= 1'b1;
            r_trgi_q <= w_trgi;
            r_edge_d <= w_edge;
            r_fall_d <= w_fall;
            r_trgi_d <= w_trgi;
        end
    end

    // Output registers
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            cnt_tick_o   <= 1'b0;
            cnt_dir_o    <= 1'b0;
            cnt_reinit_o <= 1'b0;
            cen_set_o    <= 1'b0;
            cen_clr_o    <= 1'b0;
            trgi_o       <= 1'b0;
            tif_o        <= 1'b0;
        end else begin
            cnt_tick_o   <= w_tick_n;
            cnt_dir_o    <= w_dir_n;
            cnt_reinit_o <= w_reinit_n;
            cen_set_o    <= w_set_n;
            cen_clr_o    <= w_clr_n;
            trgi_o       <= w_trgi;
            tif_o        <= w_tif_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tim_slave_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tim_slave_ctrl
// Description : Self-checking bench for tim_slave_ctrl. Directed scenarios
//               followed by randomized segments, all checked against a
//               history-based reference model of the slave-mode rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tim_slave_ctrl;

    localparam int NCYC = 4000;

    logic       clk_i = 1'b0;
    logic       aresetn_i;
    logic [2:0] sms_i;
    logic [2:0] ts_i;
    logic       msm_i, cen_i, opm_i, dir_i, uev_i;
    logic [3:0] itr_i;
    logic       ti1f_ed_i, ti1fp1_i, ti2fp2_i, etrf_i;
    logic       cnt_tick_o, cnt_dir_o, cnt_reinit_o, cen_set_o, cen_clr_o, trgi_o, tif_o;

    tim_slave_ctrl #(.ITR_NUM(4)) dut (
        .clk_i        (clk_i),
        .aresetn_i    (aresetn_i),
        .sms_i        (sms_i),
        .ts_i         (ts_i),
        .msm_i        (msm_i),
        .cen_i        (cen_i),
        .opm_i        (opm_i),
        .dir_i        (dir_i),
        .uev_i        (uev_i),
        .itr_i        (itr_i),
        .ti1f_ed_i    (ti1f_ed_i),
        .ti1fp1_i     (ti1fp1_i),
        .ti2fp2_i     (ti2fp2_i),
        .etrf_i       (etrf_i),
        .cnt_tick_o   (cnt_tick_o),
        .cnt_dir_o    (cnt_dir_o),
        .cnt_reinit_o (cnt_reinit_o),
        .cen_set_o    (cen_set_o),
        .cen_clr_o    (cen_clr_o),
        .trgi_o       (trgi_o),
        .tif_o        (tif_o)
    );

    always #5 clk_i = ~clk_i;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;
    int start = 0;
    bit m_dir = 1'b0;

    // Input history, one entry per clock cycle
    bit [2:0] h_sms [NCYC];
    bit [2:0] h_ts  [NCYC];
    bit [3:0] h_itr [NCYC];
    bit       h_msm [NCYC], h_cen [NCYC], h_opm [NCYC], h_dir [NCYC], h_uev [NCYC];
    bit       h_ed  [NCYC], h_ti1 [NCYC], h_ti2 [NCYC], h_etr [NCYC];

    task automatic check_eq(input string tag, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, act, exp);
        end
    endtask

    function automatic bit trgi_at(int k);
        case (h_ts[k])
            3'd4:    return h_ed[k];
            3'd5:    return h_ti1[k];
            3'd6:    return h_ti2[k];
            3'd7:    return h_etr[k];
            default: return h_itr[k][h_ts[k][1:0]];
        endcase
    endfunction

    // An edge only counts when the previous cycle was active with same mode/source
    function automatic bit stable_at(int k);
        return (k > start) && (h_sms[k] == h_sms[k-1]) && (h_ts[k] == h_ts[k-1]);
    endfunction

    function automatic bit edge_at(int k);
        if (!stable_at(k)) return 1'b0;
        if (h_ts[k] == 3'd4) return h_ed[k];
        return trgi_at(k) && !trgi_at(k-1);
    endfunction

    function automatic bit fall_at(int k);
        if (!stable_at(k)) return 1'b0;
        return !trgi_at(k) && trgi_at(k-1);
    endfunction

    // Quadrature position of the (TI1,TI2) pair along the forward sequence
    function automatic int phase(bit a, bit b);
        case ({a, b})
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check_cycle(input int k);
        int s, d;
        bit edg, fal, trg, enc_tick, chan1, sel;
        bit e_tick, e_dir, e_reinit, e_set, e_clr, e_tif;
        s = int'(h_sms[k]);
        if (h_msm[k]) begin
            edg = (k > start) ? edge_at(k-1) : 1'b0;
            fal = (k > start) ? fall_at(k-1) : 1'b0;
            trg = (k > start) ? trgi_at(k-1) : 1'b0;
        end else begin
            edg = edge_at(k);
            fal = fall_at(k);
            trg = trgi_at(k);
        end
        enc_tick = 1'b0;
        if (k > start && s >= 1 && s <= 3) begin
            d = (phase(h_ti1[k], h_ti2[k]) - phase(h_ti1[k-1], h_ti2[k-1]) + 4) % 4;
            if (d == 1 || d == 3) begin
                chan1 = (h_ti1[k] != h_ti1[k-1]);
                sel   = chan1 ? (s == 2 || s == 3) : (s == 1 || s == 3);
                if (sel) begin
                    m_dir    = (d == 3);
                    enc_tick = h_cen[k];
                end
            end
        end
        e_dir    = (s >= 1 && s <= 3) ? m_dir : h_dir[k];
        e_reinit = (s == 4) && edg;
        e_clr    = h_opm[k] && h_uev[k] && h_cen[k];
        e_set    = (s == 6) && edg && !h_cen[k] && !e_clr;
        case (s)
            1, 2, 3: e_tick = enc_tick;
            5:       e_tick = h_cen[k] && trg;
            7:       e_tick = h_cen[k] && edg;
            default: e_tick = h_cen[k];
        endcase
        case (s)
            4, 6, 7: e_tif = edg;
            5:       e_tif = edg || fal;
            default: e_tif = 1'b0;
        endcase
        check_eq("tick",   cnt_tick_o,   e_tick);
        check_eq("dir",    cnt_dir_o,    e_dir);
        check_eq("reinit", cnt_reinit_o, e_reinit);
        check_eq("censet", cen_set_o,    e_set);
        check_eq("cenclr", cen_clr_o,    e_clr);
        check_eq("trgi",   trgi_o,       trgi_at(k));
        check_eq("tif",    tif_o,        e_tif);
    endtask

    // Record the inputs of this cycle, clock once, check the outputs
    task automatic step();
        if (cyc < NCYC) begin
            h_sms[cyc] = sms_i;  h_ts[cyc]  = ts_i;     h_itr[cyc] = itr_i;
            h_msm[cyc] = msm_i;  h_cen[cyc] = cen_i;    h_opm[cyc] = opm_i;
            h_dir[cyc] = dir_i;  h_uev[cyc] = uev_i;    h_ed[cyc]  = ti1f_ed_i;
            h_ti1[cyc] = ti1fp1_i; h_ti2[cyc] = ti2fp2_i; h_etr[cyc] = etrf_i;
            @(posedge clk_i);
            #1;
            check_cycle(cyc);
            cyc++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic quad(input bit a, input bit b);
        ti1fp1_i = a;
        ti2fp2_i = b;
        step();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tick"},   cnt_tick_o,   1'b0);
        check_eq({tag, "_dir"},    cnt_dir_o,    1'b0);
        check_eq({tag, "_reinit"}, cnt_reinit_o, 1'b0);
        check_eq({tag, "_censet"}, cen_set_o,    1'b0);
        check_eq({tag, "_cenclr"}, cen_clr_o,    1'b0);
        check_eq({tag, "_trgi"},   trgi_o,       1'b0);
        check_eq({tag, "_tif"},    tif_o,        1'b0);
    endtask

    task automatic random_segments(input int nseg);
        int len;
        for (int sg = 0; sg < nseg && cyc < NCYC - 40; sg++) begin
            sms_i = 3'($urandom_range(0, 7));
            ts_i  = 3'($urandom_range(0, 7));
            msm_i = 1'($urandom_range(0, 1));
            opm_i = 1'($urandom_range(0, 1));
            len   = $urandom_range(4, 24);
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 3) == 0) ti1fp1_i = ~ti1fp1_i;
                if ($urandom_range(0, 3) == 0) ti2fp2_i = ~ti2fp2_i;
                if ($urandom_range(0, 3) == 0) etrf_i   = ~etrf_i;
                if ($urandom_range(0, 9) == 0) cen_i    = ~cen_i;
                if ($urandom_range(0, 7) == 0) dir_i    = ~dir_i;
                itr_i     = itr_i ^ (4'($urandom) & 4'($urandom));
                ti1f_ed_i = ($urandom_range(0, 2) == 0);
                uev_i     = ($urandom_range(0, 7) == 0);
                step();
            end
        end
    endtask

    initial begin
        aresetn_i = 1'b0;
        sms_i = 3'd0; ts_i = 3'd0; msm_i = 1'b0; cen_i = 1'b0; opm_i = 1'b0;
        dir_i = 1'b0; uev_i = 1'b0; itr_i = 4'd0;
        ti1f_ed_i = 1'b0; ti1fp1_i = 1'b0; ti2fp2_i = 1'b0; etrf_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check_all_zero("rst");
        aresetn_i = 1'b1;
        start = cyc;

        // Reset mode on TI1FP1 rising edge
        sms_i = 3'd4; ts_i = 3'd5; cen_i = 1'b1;
        steps(10);
        ti1fp1_i = 1'b1;
        steps(5);

        // Gated mode on ETRF, without and with master/slave delay
        sms_i = 3'd5; ts_i = 3'd7;
        steps(4);
        etrf_i = 1'b1; steps(10);
        etrf_i = 1'b0; steps(4);
        msm_i = 1'b1; steps(2);
        etrf_i = 1'b1; steps(10);
        etrf_i = 1'b0; steps(4);
        msm_i = 1'b0;

        // Trigger mode plus one-pulse stop
        sms_i = 3'd6; ts_i = 3'd0; opm_i = 1'b1; cen_i = 1'b0;
        steps(3);
        itr_i = 4'b0001; steps(2);
        cen_i = 1'b1; steps(5);
        uev_i = 1'b1; step();
        uev_i = 1'b0; steps(3);
        opm_i = 1'b0;

        // Encoder both: forward, reverse, then an illegal double toggle
        sms_i = 3'd3; ti1fp1_i = 1'b0; ti2fp2_i = 1'b0;
        steps(3);
        quad(1, 0); quad(1, 1); quad(0, 1); quad(0, 0);
        quad(0, 1); quad(1, 1); quad(1, 0); quad(0, 0);
        quad(1, 1); quad(1, 1);

        // External clock 1 on TI1 edge pulses, with and without CEN
        sms_i = 3'd7; ts_i = 3'd4; cen_i = 1'b1;
        steps(2);
        for (int p = 0; p < 2; p++) begin
            ti1f_ed_i = 1'b1; steps(2);
            ti1f_ed_i = 1'b0; steps(4);
            ti1f_ed_i = 1'b1; step();
            ti1f_ed_i = 1'b0; steps(2);
            cen_i = 1'b0;
        end

        // Source switch must not generate an edge
        sms_i = 3'd4; ts_i = 3'd5; ti1fp1_i = 1'b0; ti2fp2_i = 1'b1; cen_i = 1'b1;
        steps(3);
        ts_i = 3'd6; steps(3);

        // Asynchronous reset in the middle of a gated count
        sms_i = 3'd5; ts_i = 3'd7; etrf_i = 1'b1; cen_i = 1'b1; msm_i = 1'b0;
        steps(5);
        #2;
        aresetn_i = 1'b0;
        #1;
        check_all_zero("arst");
        repeat (2) @(posedge clk_i);
        #1;
        aresetn_i = 1'b1;
        start = cyc;
        m_dir = 1'b0;

        random_segments(150);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
